serial_adder: RTL
=================

# serial_adder

Multi-cycle, bit-serial adder that computes `a + b + c_in` over `WIDTH` operand bits. It uses a single `full_adder` cell and a registered carry, one bit per clock, LSB first. It sits directly upstream of any wide datapath that needs an adder result but cannot afford a `WIDTH`-bit ripple chain. It accepts operands with a start/busy/done handshake and holds the registered result until the next completion.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range `WIDTH >= 2`.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `start`  input  1: request an operation; sampled only in `IDLE`.
- `a`  input  `WIDTH`: operand A; captured on the accepting edge only.
- `b`  input  `WIDTH`: operand B; captured on the accepting edge only.
- `c_in`  input  1: carry-in; captured on the accepting edge only.
- `busy`  output  1: high while in `RUN`.
- `done`  output  1: one-cycle pulse, high while in `DONE`.
- `sum`  output  `WIDTH`: registered result `(a+b+c_in) mod 2^WIDTH`.
- `c_out`  output  1: registered carry-out of the full `WIDTH`-bit sum.

## Operation
- **States:** `IDLE`, `RUN`, `DONE`.
- **Internal registers:**
  - shift registers `a_sr`, `b_sr`, `s_sr` (`WIDTH` each);
  - `carry` (1 bit);
  - bit counter `cnt`, `$clog2(WIDTH)` bits.
- **`IDLE`:** if `start`=1 at a rising edge, then:
  - `a_sr`<=`a`, `b_sr`<=`b`, `carry`<=`c_in`, `cnt`<=0;
  - go to `RUN`.
  - Otherwise stay in `IDLE`.
- **`RUN`, each edge:**
  - `full_adder` inputs are `a_sr[0]`, `b_sr[0]`, `carry`;
  - `s_sr`<={fa_sum, s_sr[WIDTH-1:1]};
  - `a_sr` and `b_sr` shift right by one;
  - `carry`<=fa_c_out;
  - `cnt`<=`cnt`+1.
- **`RUN`, final edge** (`cnt`==WIDTH-1):
  - `sum`<={fa_sum, s_sr[WIDTH-1:1]}, `c_out`<=fa_c_out;
  - go to `DONE`.
- **`DONE`:** `done`=1 for exactly one cycle; next edge returns unconditionally to `IDLE`.
- **`start` handling:** ignored in `RUN` and `DONE`; a pending request is not queued.
- **Result hold:** `sum` and `c_out` change only on the final `RUN` edge or on reset, and hold otherwise. Intermediate bits are never visible on `sum`.
- **Reset, including mid-operation:**
  - state goes to `IDLE`;
  - all shift registers, `carry` and `cnt` go to 0;
  - `sum`=0, `c_out`=0, `busy`=0, `done`=0;
  - no `done` pulse is issued for the aborted operation.
- **Arithmetic:** `c_out` is the true bit `WIDTH` of the `(WIDTH+1)`-bit sum. Overflow wraps in `sum`.

## Timing
- Let the accepting edge be E0.
- `busy`=1 from E0 until E`WIDTH` (`WIDTH` cycles).
- The result registers load at E`WIDTH`.
- `done`=1 in the cycle between E`WIDTH` and E`WIDTH+1`.
- **Latency:** `WIDTH`+1 cycles from E0 to the `done` cycle.
- **Throughput:** with `start` held high, one operation per `WIDTH`+2 cycles. There is one `IDLE` cycle between `DONE` and the next accept.
- `sum` and `c_out` are valid from the `done` cycle onward and stable until the next completion.
- `busy` and `done` are decoded from registered state only; no combinational path from any input to any output.

## Structure
- **Package `serial_adder_pkg`:**
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} state_t`;
  - constant `DEFAULT_WIDTH = 8`.
- **Sub-module:** one instance of the existing `full_adder` (ports `a`, `b`, `c_in`, `sum`, `c_out`) as the serial bit cell. Everything else lives in `serial_adder`.

## Test plan
- **Basic adds:** `WIDTH`=8.
  - a=0x00, b=0x00, c_in=0 -> `sum`=0x00, `c_out`=0;
  - a=0x7F, b=0x01, c_in=0 -> `sum`=0x80, `c_out`=0.
  - Check `done` appears exactly 9 cycles after the accepting edge.
- **Carry propagation:**
  - a=0xFF, b=0x01, c_in=0 -> `sum`=0x00, `c_out`=1;
  - a=0xA5, b=0x5A, c_in=1 -> `sum`=0x00, `c_out`=1.
- **Start while busy:** start a=0x10, b=0x20. Pulse `start` with a=0xFF, b=0xFF at cycle 3 of `RUN`.
  - Required: `sum`=0x30, `c_out`=0, a single `done` pulse.
  - Required: `sum` keeps its previous value throughout `RUN`.
- **Reset mid-operation:** assert `rst` during `RUN` cycle 4.
  - Required next cycle: `busy`=0, `sum`=0, `c_out`=0.
  - Required: no `done`; a following operation 0x03+0x04 -> 0x07.
- **Back-to-back:** hold `start`=1 with changing operands.
  - Required: `done` every 10 cycles.
  - Required: each result matches the operands sampled at its accepting edge.
- **Randomised:** 1000 random a, b, c_in -> `{c_out, sum}` == a+b+c_in. Repeat with `WIDTH`=2 and `WIDTH`=16.

Source files
------------

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encoding and default width for serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder cell used as the serial bit slice.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic w_half;

    assign w_half = a ^ b;
    assign sum    = w_half ^ c_in;
    assign c_out  = (a & b) | (c_in & w_half);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder, LSB first, one bit per clock through a single
//               full_adder cell; start/busy/done handshake, held result.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;

    logic             w_fa_sum;
    logic             w_fa_c_out;
    logic             w_last_bit;
    logic [WIDTH-1:0] w_s_shifted;

    full_adder u_bit_cell (
        .a     (r_a_sr[0]),
        .b     (r_b_sr[0]),
        .c_in  (r_carry),
        .sum   (w_fa_sum),
        .c_out (w_fa_c_out)
    );

    assign w_last_bit  = (r_cnt == c_LAST);
    // New bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
    assign w_s_shifted = {w_fa_sum, r_s_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last_bit) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= c_in;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_s_sr  <= w_s_shifted;
                    r_carry <= w_fa_c_out;
                    r_cnt   <= r_cnt + 1'b1;
                    // Result is published only once complete; partial bits stay internal.
                    if (w_last_bit) begin
                        r_sum   <= w_s_shifted;
                        r_c_out <= w_fa_c_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);
    assign sum   = r_sum;
    assign c_out = r_c_out;

endmodule : serial_adder
`default_nettype wire
